// File: rtl/aes192_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helper for the AES-192 key schedule.
package aes192_pkg;

    localparam int NK        = 6;
    localparam int NR        = 12;
    localparam int NUM_RK    = 13;
    localparam int NUM_WORDS = 52;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Multiply by x in GF(2^8) with the AES reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in and one byte out.
module aes_sbox (
    input  logic [7:0] sel_byte,
    output logic [7:0] sub_byte
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Straight table lookup.
    always_comb begin
        sub_byte = SBOX[sel_byte];
    end

endmodule

// File: rtl/aes192_key_expand.sv
// Iterative AES-192 key expansion: one schedule word per clock, 46 cycles per key.
module aes192_key_expand
    import aes192_pkg::*;
#(
    parameter int NUM_RK    = 13,
    parameter int KEY_WIDTH = 192
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic [KEY_WIDTH-1:0]    key_in,
    input  logic                    key_valid,
    output logic                    key_ready,
    output logic [128*NUM_RK-1:0]   rk_flat,
    output logic                    keys_valid
);

    state_t      state;
    logic [5:0]  idx;
    logic [7:0]  rcon;
    logic [31:0] words [aes192_pkg::NUM_WORDS];

    logic [5:0]  prev_sel;
    logic [5:0]  back_sel;
    logic [31:0] prev_word;
    logic [31:0] back_word;
    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic        rcon_step;
    logic [31:0] temp_word;
    logic [31:0] new_word;

    // Pick w[i-1] and w[i-6]; outside EXPAND idx can be below 6, so clamp to a legal address.
    always_comb begin
        prev_sel  = 6'd0;
        back_sel  = 6'd0;
        if (idx >= 6'(NK)) begin
            prev_sel = idx - 6'd1;
            back_sel = idx - 6'(NK);
        end
        prev_word = words[prev_sel];
        back_word = words[back_sel];
        rot_word  = {prev_word[23:0], prev_word[31:24]};
    end

    genvar b;
    generate
        for (b = 0; b < 4; b++) begin : g_subword
            aes_sbox u_sbox (
                .sel_byte (rot_word[8*b +: 8]),
                .sub_byte (sub_word[8*b +: 8])
            );
        end
    endgenerate

    // Next schedule word; every sixth word goes through RotWord/SubWord/Rcon.
    always_comb begin
        rcon_step = ((idx % 6'(NK)) == 6'd0);
        temp_word = rcon_step ? (sub_word ^ {rcon, 24'h000000}) : prev_word;
        new_word  = back_word ^ temp_word;
    end

    // Control FSM and word store; reset clears everything so a partial schedule never lingers.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state      <= ST_IDLE;
            key_ready  <= 1'b1;
            keys_valid <= 1'b0;
            idx        <= 6'd0;
            rcon       <= 8'h01;
            for (int k = 0; k < aes192_pkg::NUM_WORDS; k++) begin
                words[k] <= 32'h0;
            end
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (key_valid && key_ready) begin
                        for (int k = 0; k < NK; k++) begin
                            words[k] <= key_in[KEY_WIDTH-1-32*k -: 32];
                        end
                        idx        <= 6'(NK);
                        rcon       <= 8'h01;
                        state      <= ST_EXPAND;
                        key_ready  <= 1'b0;
                        keys_valid <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    words[idx] <= new_word;
                    if (rcon_step) begin
                        rcon <= xtime(rcon);
                    end
                    if (idx == 6'(aes192_pkg::NUM_WORDS - 1)) begin
                        state      <= ST_DONE;
                        key_ready  <= 1'b1;
                        keys_valid <= 1'b1;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    key_ready  <= 1'b1;
                    keys_valid <= 1'b0;
                end
            endcase
        end
    end

    // Round key r packs w[4r]..w[4r+3], with w[4r] in the top 32 bits.
    always_comb begin
        rk_flat = '0;
        for (int r = 0; r < NUM_RK; r++) begin
            for (int c = 0; c < 4; c++) begin
                rk_flat[128*r + 32*(3-c) +: 32] = words[4*r + c];
            end
        end
    end

endmodule

// File: tb/tb_aes192_key_expand.sv
// Directed bench for aes192_key_expand using FIPS-197 AES-192 vectors.
module tb_aes192_key_expand;

    logic           ap_clk;
    logic           ap_rst;
    logic [191:0]   key_in;
    logic           key_valid;
    logic           key_ready;
    logic [1663:0]  rk_flat;
    logic           keys_valid;

    int checks = 0;
    int errors = 0;
    int lat;

    localparam logic [191:0] KEY_A = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [191:0] KEY_C = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;

    localparam logic [127:0] A_RK0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] A_RK1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    localparam logic [127:0] A_RK12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] C_RK0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_RK12 = 128'ha4970a331a78dc09c418c271e3a41d5d;

    aes192_key_expand #(
        .NUM_RK    (13),
        .KEY_WIDTH (192)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .rk_flat    (rk_flat),
        .keys_valid (keys_valid)
    );

    // Free-running 10 ns clock.
    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    function automatic logic [127:0] round_key(input int r);
        return rk_flat[128*r +: 128];
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Present a key for one edge; the DUT must be idle or done.
    task automatic applyStimulus(input logic [191:0] key);
        key_in    = key;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        checkOutput("ready_low_after_hs", 128'(key_ready), 128'd0);
        checkOutput("valid_low_after_hs", 128'(keys_valid), 128'd0);
    endtask

    // Count edges since the handshake until keys_valid rises, bounded.
    task automatic waitDone(input int start, output int cycles);
        cycles = start;
        while (!keys_valid && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        ap_rst    = 1'b1;
        key_in    = '0;
        key_valid = 1'b0;
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("rst_key_ready", 128'(key_ready), 128'd1);
        checkOutput("rst_keys_valid", 128'(keys_valid), 128'd0);
        checkOutput("rst_rk_zero", 128'(|rk_flat), 128'd0);
        ap_rst = 1'b0;
        tick();

        $display("[TB] FIPS-197 A.2 key");
        applyStimulus(KEY_A);
        waitDone(0, lat);
        checkOutput("a2_latency", 128'(lat), 128'd46);
        checkOutput("a2_key_ready", 128'(key_ready), 128'd1);
        checkOutput("a2_rk0", round_key(0), A_RK0);
        checkOutput("a2_rk1_w6w7", round_key(1), A_RK1);
        checkOutput("a2_rk12", round_key(12), A_RK12);

        $display("[TB] FIPS-197 C.2 key");
        applyStimulus(KEY_C);
        waitDone(0, lat);
        checkOutput("c2_latency", 128'(lat), 128'd46);
        checkOutput("c2_rk0", round_key(0), C_RK0);
        checkOutput("c2_rk12", round_key(12), C_RK12);

        $display("[TB] key_valid during expansion is ignored");
        applyStimulus(KEY_A);
        repeat (9) tick();
        key_in    = KEY_C;
        key_valid = 1'b1;
        checkOutput("mid_key_ready", 128'(key_ready), 128'd0);
        tick();
        key_valid = 1'b0;
        waitDone(10, lat);
        checkOutput("mid_latency", 128'(lat), 128'd46);
        checkOutput("mid_rk0", round_key(0), A_RK0);
        checkOutput("mid_rk12", round_key(12), A_RK12);

        $display("[TB] reset during expansion");
        applyStimulus(KEY_C);
        repeat (19) tick();
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        checkOutput("abort_key_ready", 128'(key_ready), 128'd1);
        checkOutput("abort_keys_valid", 128'(keys_valid), 128'd0);
        checkOutput("abort_rk_zero", 128'(|rk_flat), 128'd0);
        applyStimulus(KEY_C);
        waitDone(0, lat);
        checkOutput("after_abort_latency", 128'(lat), 128'd46);
        checkOutput("after_abort_rk12", round_key(12), C_RK12);

        $display("[TB] back-to-back key in DONE");
        applyStimulus(KEY_A);
        waitDone(0, lat);
        checkOutput("b2b_latency", 128'(lat), 128'd46);
        checkOutput("b2b_rk1", round_key(1), A_RK1);
        checkOutput("b2b_rk12", round_key(12), A_RK12);

        $display("[TB] reset and key_valid together");
        ap_rst    = 1'b1;
        key_in    = KEY_C;
        key_valid = 1'b1;
        tick();
        ap_rst    = 1'b0;
        key_valid = 1'b0;
        checkOutput("rstkey_key_ready", 128'(key_ready), 128'd1);
        checkOutput("rstkey_rk_zero", 128'(|rk_flat), 128'd0);
        repeat (5) tick();
        checkOutput("rstkey_still_idle_ready", 128'(key_ready), 128'd1);
        checkOutput("rstkey_still_zero", 128'(|rk_flat), 128'd0);
        checkOutput("rstkey_keys_valid", 128'(keys_valid), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
